uart_rx: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/bit_synchronizer.sv | 33 +++
 rtl/uart_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver (and the transmitter side).
//   UART_DATA_BITS : payload bits per frame (8N1 framing)
//   rx_state_t     : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer that brings a single asynchronous bit into the clk
// domain. Reusable for any asynchronous control input.
//   clk       : destination clock
//   rst       : asynchronous active-high reset; all stages go to RESET_VALUE
//   i_async   : asynchronous input bit
//   o_sync    : synchronized output (last stage)
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= {STAGES{RESET_VALUE}};
        end else begin
            r_stage <= {r_stage[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stage[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. Oversamples the serial line with an internal counter at
// CLKS_PER_BIT clocks per bit, samples each bit near its centre, and reports
// each received byte as a one-cycle valid pulse. A low stop bit produces a
// one-cycle framing_error pulse instead and leaves data untouched.
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset
//   rx            : serial line, asynchronous to clk, idles high
//   data          : last correctly received byte
//   valid         : one-cycle pulse, data carries the new byte in that cycle
//   framing_error : one-cycle pulse when the stop bit samples low
// CLKS_PER_BIT must be even and >= 4.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic                      r_rx_d;
    rx_state_t                 r_state;
    logic [CW-1:0]             r_cnt;
    logic [2:0]                r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_armed;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;

    bit_synchronizer #(
        .STAGES      (2),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_d  <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_armed <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            // Output strobes are single-cycle by construction.
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_rx_d  <= w_rx_s;

            case (r_state)
                IDLE: begin
                    // Only a line that has been seen high can start a frame;
                    // this keeps a held-low break from retriggering.
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && r_rx_d && !w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end

                START: begin
                    if (r_cnt == CNT_HALF) begin
                        if (!w_rx_s) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            // Line went back high before mid-bit: glitch.
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                        // Leave at mid-stop so a back-to-back start edge is
                        // caught; re-arm only if the line is already high.
                        r_armed <= w_rx_s;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data          = r_data;
    assign valid         = r_valid;
    assign framing_error = r_ferr;

endmodule : uart_rx
